// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage: Funct codes, FSM state
// encoding, the ALU_op values used by the upstream control decoder, and
// small decode helpers.
// Build option: ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter
// in place of the serial one.
package alu_pkg;

    // Funct codes produced by the ALU control decoder
    localparam logic [5:0] FUNCT_ADDU = 6'b001001;
    localparam logic [5:0] FUNCT_SUBU = 6'b001010;
    localparam logic [5:0] FUNCT_SLL  = 6'b100001;
    localparam logic [5:0] FUNCT_SLLV = 6'b110101;
    localparam logic [5:0] FUNCT_AND  = 6'b000000;

    // ALU_op values the decoder uses to pick its Funct output
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode from instruction funct
    localparam logic [1:0] ALUOP_AND   = 2'b11;  // fallback

    // Handshake / sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // True for the two shift Funct codes
    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FUNCT_SLL) || (funct == FUNCT_SLLV);
    endfunction

    // True for SLLV, whose amount comes from rs instead of shamt
    function automatic logic is_variable_shift(input logic [5:0] funct);
        return (funct == FUNCT_SLLV);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Left-shift engine for SLL/SLLV.
// Default build: a shift register and down-counter that shift one bit per
// cycle after start; 'last' flags the cycle whose edge completes the shift,
// and 'shift_out' is the value that edge produces.
// With ALU_BARREL_SHIFT_EN: purely combinational din << amount, no state.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   shift_out,
    output logic               last
);

`ifdef ALU_BARREL_SHIFT_EN

    // Sequencing inputs are not needed when the shift is combinational
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, start};

    // Whole shift in one cycle
    assign shift_out = din << amount;
    assign last      = 1'b0;

`else

    logic [WIDTH-1:0]   sreg_reg;
    logic [SHAMT_W-1:0] cnt_reg;

    // Load on start, then shift one place per cycle until the counter drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_reg <= '0;
            cnt_reg  <= '0;
        end else if (start) begin
            sreg_reg <= din;
            cnt_reg  <= amount;
        end else if (cnt_reg != '0) begin
            sreg_reg <= sreg_reg << 1;
            cnt_reg  <= cnt_reg - 1'b1;
        end
    end

    // The edge seen while cnt == 1 performs the final shift
    assign shift_out = sreg_reg << 1;
    assign last      = (cnt_reg == SHAMT_W'(1));

`endif

endmodule

// File: rtl/alu_exec_seq.sv
// ALU execution stage: takes one ALU Funct operation per valid/ready
// handshake, computes ADDU/SUBU/AND in one cycle and SLL/SLLV through
// alu_shift_unit, and holds the result under a valid/ready output handshake.
// Only one operation is in flight; a new one is accepted only in IDLE.
// Build option: ALU_BARREL_SHIFT_EN makes shifts single-cycle.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               out_valid_reg;
    logic               zero_reg;

    logic               accept;
    logic [SHAMT_W-1:0] shift_amount;
    logic               shift_start;
    logic [WIDTH-1:0]   shift_out;
    logic               shift_last;

    // in_ready must fall immediately with reset, not one edge later
    assign in_ready = (state_reg == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // SLLV takes its amount from the low bits of rs
    assign shift_amount = is_variable_shift(funct) ? src_a[SHAMT_W-1:0] : shamt;

    // Only non-zero shifts need the serial engine; zero shifts finish at accept
    assign shift_start  = accept && is_shift(funct) && (shift_amount != '0);

    alu_shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .start     (shift_start),
        .din       (src_b),
        .amount    (shift_amount),
        .shift_out (shift_out),
        .last      (shift_last)
    );

    // Next-state and next-result selection for the handshake FSM
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    case (funct)
                        FUNCT_ADDU: begin
                            result_next = src_a + src_b;
                            state_next  = DONE;
                        end
                        FUNCT_SUBU: begin
                            result_next = src_a - src_b;
                            state_next  = DONE;
                        end
                        FUNCT_SLL, FUNCT_SLLV: begin
`ifdef ALU_BARREL_SHIFT_EN
                            result_next = shift_out;
                            state_next  = DONE;
`else
                            result_next = src_b;
                            if (shift_amount == '0) begin
                                state_next = DONE;
                            end else begin
                                state_next = SHIFT;
                            end
`endif
                        end
                        // AND, and every unlisted code, matching the decoder default
                        default: begin
                            result_next = src_a & src_b;
                            state_next  = DONE;
                        end
                    endcase
                end
            end
            SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
                state_next = IDLE;
`else
                if (shift_last) begin
                    result_next = shift_out;
                    state_next  = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; zero is only ever high alongside out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            result_reg    <= result_next;
            out_valid_reg <= (state_next == DONE);
            zero_reg      <= (state_next == DONE) && (result_next == '0);
        end
    end

    assign result    = result_reg;
    assign out_valid = out_valid_reg;
    assign zero      = zero_reg;

endmodule
